// File: rtl/mem_bus_controller.sv
// Multi-cycle sized-access memory behind the MA register: captures a request, stalls for LATENCY
// wait states, then performs a byte/halfword/word read or write. Optional MEM_ACC_CNT_EN adds counters.
module mem_bus_controller #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enMem,
    input  logic        MemWrt,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  size,
    output logic [31:0] rdata,
    output logic        Busy,
    output logic        misalign
`ifdef MEM_ACC_CNT_EN
    ,
    output logic [31:0] rdCount,
    output logic [31:0] wrCount
`endif
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned AW   = IdxW + 2;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wrt_q, wrt_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          misalign_q, misalign_d;

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          req_wrt;
    logic [2:0]    req_size;
    logic [IdxW-1:0] req_idx;
    logic [1:0]    req_lo;
    logic          req_err;
    logic          enter_done;
    logic          mem_we;
    logic [31:0]   cur_word;
    logic [31:0]   load_val;
    logic [31:0]   store_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    logic unused_addr;
    assign unused_addr = ^addr[31:AW];

    // In IDLE the live inputs are used so a zero-latency access completes on the capture edge.
    assign req_addr  = (state_q == StIdle) ? addr[AW-1:0] : addr_q;
    assign req_wdata = (state_q == StIdle) ? wdata        : wdata_q;
    assign req_wrt   = (state_q == StIdle) ? MemWrt       : wrt_q;
    assign req_size  = (state_q == StIdle) ? size         : size_q;
    assign req_idx   = req_addr[AW-1:2];
    assign req_lo    = req_addr[1:0];
    assign cur_word  = mem_q[req_idx];

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = req_lo[0];
            3'b010:         req_err = (req_lo != 2'b00);
            default:        req_err = 1'b1;
        endcase
        if (req_wrt && req_size[2]) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        byte_sel = cur_word[{req_lo, 3'b000} +: 8];
        half_sel = cur_word[{req_lo[1], 4'b0000} +: 16];
        case (req_size)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'b0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'b0, half_sel};
            3'b010:  load_val = cur_word;
            default: load_val = '0;
        endcase
        if (req_err || req_wrt) begin
            load_val = '0;
        end
    end

    // Read-modify-write so only the addressed lanes change.
    always_comb begin
        store_word = cur_word;
        case (req_size[1:0])
            2'b00:   store_word[{req_lo, 3'b000} +: 8]     = req_wdata[7:0];
            2'b01:   store_word[{req_lo[1], 4'b0000} +: 16] = req_wdata[15:0];
            2'b10:   store_word                             = req_wdata;
            default: store_word                             = cur_word;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wrt_d      = wrt_q;
        size_d     = size_q;
        enter_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enMem) begin
                    addr_d  = addr[AW-1:0];
                    wdata_d = wdata;
                    wrt_d   = MemWrt;
                    size_d  = size;
                    if (LATENCY == 0) begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (!enMem) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d    = StDone;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (!enMem) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d    = '0;
        misalign_d = 1'b0;
        if (enter_done) begin
            rdata_d    = load_val;
            misalign_d = req_err;
        end else if (state_q == StDone && state_d == StDone) begin
            rdata_d    = rdata_q;
            misalign_d = misalign_q;
        end
    end

    // Gated by reset so a request held during reset can never commit.
    assign mem_we = enter_done && req_wrt && !req_err && reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wrt_q      <= 1'b0;
            size_q     <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wrt_q      <= wrt_d;
            size_q     <= size_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[req_idx] <= store_word;
        end
    end

    assign Busy     = (state_q == StIdle && enMem) || (state_q == StWait);
    assign rdata    = rdata_q;
    assign misalign = misalign_q;

`ifdef MEM_ACC_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (enter_done && !req_err) begin
            if (req_wrt) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rdCount = rd_cnt_q;
    assign wrCount = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bus_controller.sv
// Bench for mem_bus_controller: a LATENCY=2 and a LATENCY=0 instance share stimulus and are
// checked every cycle against a transaction-level model; MEM_ACC_CNT_EN enables counter checks.
module tb_mem_bus_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enMem = 1'b0;
    logic        MemWrt = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  size = '0;
    logic [31:0] rd [2];
    logic        busy [2];
    logic        mis [2];
`ifdef MEM_ACC_CNT_EN
    logic [31:0] rc [2];
    logic [31:0] wc [2];
`endif

    mem_bus_controller #(.DEPTH(1024), .LATENCY(2)) u_slow (
        .clock(clock), .reset(reset), .enMem(enMem), .MemWrt(MemWrt), .addr(addr),
        .wdata(wdata), .size(size), .rdata(rd[0]), .Busy(busy[0]), .misalign(mis[0])
`ifdef MEM_ACC_CNT_EN
        , .rdCount(rc[0]), .wrCount(wc[0])
`endif
    );

    mem_bus_controller #(.DEPTH(1024), .LATENCY(0)) u_fast (
        .clock(clock), .reset(reset), .enMem(enMem), .MemWrt(MemWrt), .addr(addr),
        .wdata(wdata), .size(size), .rdata(rd[1]), .Busy(busy[1]), .misalign(mis[1])
`ifdef MEM_ACC_CNT_EN
        , .rdCount(rc[1]), .wrCount(wc[1])
`endif
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int          lat [2];
    bit          chk_en = 1'b0;
    logic        exp_busy [2];
    logic [31:0] exp_rd [2];
    logic        exp_mis [2];
    logic [31:0] mm [2][1024];
    int          rcm [2];
    int          wcm [2];
    logic [31:0] obs [2];
    logic        obs_mis [2];

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endfunction

    function automatic bit merr(input bit wr, input logic [2:0] sz, input logic [1:0] lo);
        bit e;
        if (sz == 3'b000 || sz == 3'b100) e = 1'b0;
        else if (sz == 3'b001 || sz == 3'b101) e = lo[0];
        else if (sz == 3'b010) e = (lo != 2'b00);
        else e = 1'b1;
        if (wr && sz[2]) e = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] w, input logic [2:0] sz,
                                          input logic [1:0] lo);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * lo[1])) & 32'hFFFF;
        case (sz)
            3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] mwrite(input logic [31:0] w, input logic [31:0] wd,
                                           input logic [2:0] sz, input logic [1:0] lo);
        logic [31:0] m;
        logic [31:0] v;
        if (sz == 3'b000) begin
            m = 32'hFF << (8 * lo);
            v = (wd & 32'hFF) << (8 * lo);
        end else if (sz == 3'b001) begin
            m = 32'hFFFF << (16 * lo[1]);
            v = (wd & 32'hFFFF) << (16 * lo[1]);
        end else begin
            m = 32'hFFFF_FFFF;
            v = wd;
        end
        return (w & ~m) | v;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("busy[%0d]", d), {31'b0, busy[d]}, {31'b0, exp_busy[d]});
                check($sformatf("rdata[%0d]", d), rd[d], exp_rd[d]);
                check($sformatf("misalign[%0d]", d), {31'b0, mis[d]}, {31'b0, exp_mis[d]});
            end
        end
    end

    task automatic set_idle_exp();
        for (int d = 0; d < 2; d++) begin
            exp_busy[d] = 1'b0;
            exp_rd[d]   = '0;
            exp_mis[d]  = 1'b0;
        end
    endtask

    // enMem held for h cycles; the access completes on a device iff h > its latency.
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] sz, input int h);
        bit          err;
        bit          done;
        logic [31:0] rv [2];
        err = merr(wr, sz, a[1:0]);
        for (int d = 0; d < 2; d++) begin
            rv[d]      = (err || wr) ? 32'h0 : mread(mm[d][a[11:2]], sz, a[1:0]);
            obs[d]     = 'x;
            obs_mis[d] = 1'bx;
        end
        for (int k = 0; k <= h + 1; k++) begin
            @(posedge clock);
            #1;
            enMem  = (k < h);
            MemWrt = wr;
            addr   = a;
            wdata  = wd;
            size   = sz;
            for (int d = 0; d < 2; d++) begin
                if (k <= h) begin
                    done        = (k > lat[d]);
                    exp_busy[d] = (k == 0) || (k <= lat[d]);
                    exp_rd[d]   = done ? rv[d] : 32'h0;
                    exp_mis[d]  = done && err;
                end else begin
                    exp_busy[d] = 1'b0;
                    exp_rd[d]   = '0;
                    exp_mis[d]  = 1'b0;
                end
            end
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (k == lat[d] + 1 && k <= h) begin
                    obs[d]     = rd[d];
                    obs_mis[d] = mis[d];
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (h >= lat[d] + 1 && !err) begin
                if (wr) begin
                    mm[d][a[11:2]] = mwrite(mm[d][a[11:2]], wd, sz, a[1:0]);
                    wcm[d]++;
                end else begin
                    rcm[d]++;
                end
            end
`ifdef MEM_ACC_CNT_EN
            check($sformatf("wrCount[%0d]", d), wc[d], wcm[d]);
            check($sformatf("rdCount[%0d]", d), rc[d], rcm[d]);
`endif
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        enMem = 1'b0;
        set_idle_exp();
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rcm[d] = 0;
            wcm[d] = 0;
        end
    endtask

    // Reset lands in the cycle after capture: slow device is in WAIT, fast one already wrote.
    task automatic reset_abort(input logic [31:0] a, input logic [31:0] wd);
        @(posedge clock);
        #1;
        enMem  = 1'b1;
        MemWrt = 1'b1;
        addr   = a;
        wdata  = wd;
        size   = 3'b010;
        for (int d = 0; d < 2; d++) begin
            exp_busy[d] = 1'b1;
            exp_rd[d]   = '0;
            exp_mis[d]  = 1'b0;
        end
        mm[1][a[11:2]] = wd;
        do_reset();
    endtask

    initial begin
        lat[0] = 2;
        lat[1] = 0;
        for (int d = 0; d < 2; d++) begin
            rcm[d] = 0;
            wcm[d] = 0;
        end
        set_idle_exp();
        chk_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        for (int w = 0; w < 16; w++) begin
            access(1'b1, 32'(w * 4), $urandom, 3'b010, 3);
        end

        access(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 3);
        access(1'b0, 32'h10, 32'h0, 3'b010, 3);
        check("lw_10", obs[0], 32'hDEADBEEF);
        check("lw_10_lat0", obs[1], 32'hDEADBEEF);

        access(1'b1, 32'h11, 32'h7F, 3'b000, 3);
        access(1'b0, 32'h10, 32'h0, 3'b010, 3);
        check("sb_then_lw", obs[0], 32'hDEAD7FEF);
        access(1'b0, 32'h13, 32'h0, 3'b000, 3);
        check("lb_13", obs[0], 32'hFFFFFFDE);
        access(1'b0, 32'h13, 32'h0, 3'b100, 3);
        check("lbu_13", obs[0], 32'h000000DE);
        access(1'b0, 32'h12, 32'h0, 3'b001, 3);
        check("lh_12", obs[0], 32'hFFFFDEAD);

        access(1'b0, 32'h12, 32'h0, 3'b010, 3);
        check("lw_12_mis", {31'b0, obs_mis[0]}, 32'd1);
        check("lw_12_data", obs[0], 32'h0);
        access(1'b1, 32'h20, 32'h11223344, 3'b010, 3);
        access(1'b1, 32'h21, 32'h1234, 3'b001, 3);
        check("sh_21_mis", {31'b0, obs_mis[0]}, 32'd1);
        access(1'b0, 32'h20, 32'h0, 3'b010, 3);
        check("lw_20_unchanged", obs[0], 32'h11223344);

        access(1'b1, 32'h30, 32'h55555555, 3'b010, 3);
        reset_abort(32'h30, 32'hAAAAAAAA);
        access(1'b0, 32'h30, 32'h0, 3'b010, 3);
        check("lw_30_after_reset", obs[0], 32'h55555555);
        check("lw_30_lat0_committed", obs[1], 32'hAAAAAAAA);

        access(1'b1, 32'h40, 32'h01020304, 3'b010, 3);
        access(1'b1, 32'h40, 32'hFFFFFFFF, 3'b010, 2);
        access(1'b0, 32'h40, 32'h0, 3'b010, 3);
        check("lw_40_after_drop", obs[0], 32'h01020304);

        access(1'b0, 32'h1010, 32'h0, 3'b010, 3);
        check("lw_1010_alias", obs[0], 32'hDEAD7FEF);

`ifdef MEM_ACC_CNT_EN
        do_reset();
        access(1'b1, 32'h08, 32'h0BADF00D, 3'b010, 3);
        access(1'b1, 32'h0C, 32'hCAFEF00D, 3'b010, 3);
        access(1'b0, 32'h08, 32'h0, 3'b010, 3);
        access(1'b0, 32'h0C, 32'h0, 3'b010, 3);
        access(1'b0, 32'h10, 32'h0, 3'b010, 3);
        access(1'b0, 32'h12, 32'h0, 3'b010, 3);
        check("cnt_wr_slow", wc[0], 32'd2);
        check("cnt_rd_slow", rc[0], 32'd3);
        check("cnt_wr_fast", wc[1], 32'd2);
        check("cnt_rd_fast", rc[1], 32'd3);
`endif

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            access(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                   $urandom_range(1, 5));
        end

        @(posedge clock);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_controller.md
Name: mem_bus_controller

Overview:
- Multi-cycle data/instruction memory that sits directly downstream of the bus-based datapath's MA register and shared bus.
- Captures an access request, holds Busy high for a parameterised number of wait states, then performs a sized read or write.
- Busy stalls the microcoded control unit; read data is returned on rdata for the datapath to place on the shared bus.

Parameters:
- DEPTH, 1024, number of 32-bit words in storage; must be a power of 2.
- LATENCY, 2, wait-state cycles between request capture and data phase; legal range 0..15.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enMem  in  1  access request; held high by control until the access completes.
- MemWrt  in  1  1 = write, 0 = read; sampled with enMem.
- addr  in  32  byte address from MA.
- wdata  in  32  store data from the shared bus.
- size  in  3  funct3 access size/sign code.
- rdata  out  32  read data; valid only in DONE.
- Busy  out  1  stall request to control.
- misalign  out  1  access error flag; valid only in DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; Busy=0, rdata=0, misalign=0, wait counter=0, captured request cleared.
  - Storage contents are not cleared.
  - Reset mid-access aborts the access; no write occurs.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: when enMem=1, capture addr/wdata/MemWrt/size on the edge. Go to WAIT with counter=LATENCY-1, or directly to DONE if LATENCY=0.
  - WAIT: decrement the counter each cycle; when the counter is 0, go to DONE.
  - DONE: hold until enMem=0, then go to IDLE.
  - enMem dropping during WAIT aborts: return to IDLE, no write.
- Busy is combinational and asserted when (state==IDLE && enMem) or state==WAIT. It is low in DONE and in IDLE without a request.
- Request to data latency: the first DONE cycle occurs LATENCY+1 edges after capture.
- Word index = addr[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Write:
  - Committed on the edge entering DONE, exactly once.
  - size 000 writes byte lane addr[1:0]; 001 writes halfword lane addr[1]; 010 writes the full word.
  - Only the selected lanes change.
- Read data is registered on entry to DONE and held stable through DONE:
  - 000 LB: sign-extended byte.
  - 100 LBU: zero-extended byte.
  - 001 LH: sign-extended halfword.
  - 101 LHU: zero-extended halfword.
  - 010 LW: full word.
- Error cases: misalign=1 in DONE and no write, rdata=0 when any of:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - size 011/110/111;
  - store with size bit2=1.
- Outside DONE, rdata=0 and misalign=0.
- A new request is accepted only from IDLE; back-to-back accesses therefore need at least one cycle with enMem=0.

Optional Feature:
- Macro MEM_ACC_CNT_EN.
- When defined:
  - Adds outputs rdCount[31:0] and wrCount[31:0], reset to 0.
  - Each increments by 1 on entry to DONE for a non-misaligned read or write respectively, wrapping at 2^32.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- LATENCY=2. Sequence: SW 0xDEADBEEF to 0x10, then LW 0x10.
  - Busy is high for 3 cycles from the request cycle.
  - rdata=0xDEADBEEF in DONE.
- Byte lanes on word 0x10=0xDEADBEEF:
  - SB 0x7F to 0x11, then LW 0x10 gives 0xDEAD7FEF.
  - LB 0x13 gives 0xFFFFFFDE; LBU 0x13 gives 0x000000DE.
  - LH 0x12 gives 0xFFFFDEAD.
- Misaligned accesses:
  - LW 0x12: misalign=1, rdata=0.
  - SH 0x21 of 0x1234: misalign=1; a following LW 0x20 is unchanged.
- Aborts:
  - Assert reset during WAIT of SW 0xAAAAAAAA to 0x30, after preloading 0x30=0x55555555. State returns to IDLE, Busy=0, and LW 0x30 reads 0x55555555.
  - Dropping enMem during WAIT also leaves memory unchanged.
- Timing and wrap:
  - LATENCY=0: LW returns data the cycle after the request, with Busy high only in the request cycle.
  - With DEPTH=1024, address 0x1010 aliases to 0x10.
- Counters, with MEM_ACC_CNT_EN defined: 2 writes, 3 reads and 1 misaligned read give wrCount=2, rdCount=3.
